// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op encodings and default latencies for the multiply/divide unit
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - execute-stage multiply/divide unit holding HI/LO with fixed-latency completion
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  logic [CNT_W-1:0] count;
  logic [31:0]      pending_hi;
  logic [31:0]      pending_lo;
  logic             pending_wr;

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_wr;
  logic [CNT_W-1:0] res_lat;
  md_op_e           op_e;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow.
  assign a_mag = A[31] ? (~A + 32'd1) : A;
  assign b_mag = B[31] ? (~B + 32'd1) : B;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;

  always_comb begin
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_wr  = 1'b0;
    res_lat = CNT_W'(MULT_CYCLES);
    op_e    = md_op_e'(op);
    case (op_e)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      MD_DIV: begin
        res_lat = CNT_W'(DIV_CYCLES);
        res_lo  = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        res_hi  = A[31] ? (~r_mag + 32'd1) : r_mag;
        res_wr  = (B != 32'd0);
      end
      MD_DIVU: begin
        res_lat = CNT_W'(DIV_CYCLES);
        res_lo  = A / B;
        res_hi  = A % B;
        res_wr  = (B != 32'd0);
      end
      default: begin
        res_wr = 1'b0;
      end
    endcase
  end

  // Completion outranks everything; start and mthi/mtlo are only honoured while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      count      <= '0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_wr <= 1'b0;
      HI         <= 32'd0;
      LO         <= 32'd0;
    end else if (busy) begin
      if (count == CNT_W'(1)) begin
        busy  <= 1'b0;
        count <= '0;
        if (pending_wr) begin
          HI <= pending_hi;
          LO <= pending_lo;
        end
      end else begin
        count <= count - CNT_W'(1);
      end
    end else if (start) begin
      busy       <= 1'b1;
      count      <= res_lat;
      pending_hi <= res_hi;
      pending_lo <= res_lo;
      pending_wr <= res_wr;
    end else begin
      if (hi_we) HI <= wd;
      if (lo_we) LO <= wd;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized and directed self-checking bench for md_unit
module tb_md_unit;
  import md_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .HI(hi), .LO(lo)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference arithmetic done with 64-bit integers straight from the op definitions.
  function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    rh = 32'd0;
    rl = 32'd0;
    wr = 1'b0;
    case (o)
      2'd0: begin q = sx * sy; rh = q[63:32]; rl = q[31:0]; wr = 1'b1; end
      2'd1: begin uq = ux * uy; rh = uq[63:32]; rl = uq[31:0]; wr = 1'b1; end
      2'd2: if (y != 32'd0) begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; wr = 1'b1; end
      default: if (y != 32'd0) begin uq = ux / uy; ur = ux % uy; rl = uq[31:0]; rh = ur[31:0]; wr = 1'b1; end
    endcase
  endfunction

  // Model tracks absolute edge numbers: an op accepted at edge e completes at edge e+latency.
  int          edge_no;
  int          done_at;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;
  bit          m_busy;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_no = 0;
      done_at = 0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      p_wr    = 1'b0;
      m_busy  = 1'b0;
    end else begin
      edge_no++;
      if (edge_no - 1 < done_at) begin
        if (edge_no == done_at && p_wr) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end else if (start) begin
        model_op(op, a, b, p_hi, p_lo, p_wr);
        done_at = edge_no + ((op >= 2'd2) ? DIV_LAT : MULT_LAT);
      end else begin
        if (hi_we) m_hi = wd;
        if (lo_we) m_lo = wd;
      end
      m_busy = (edge_no < done_at);
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en && reset === 1'b1) begin
      check("cycle busy", {31'd0, busy}, {31'd0, m_busy});
      check("cycle HI", hi, m_hi);
      check("cycle LO", lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int lat,
                        input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check({name, " latency"}, n, lat);
    check({name, " HI"}, hi, exp_hi);
    check({name, " LO"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] pick_operand(input bit allow_zero);
    case ($urandom % 8)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return allow_zero ? 32'd0 : 32'd1;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    wd = 32'd0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", hi, 32'd0);
    check("reset LO", lo, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    step();

    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3,         MULT_LAT, "mult",     32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, "multu",    32'hFFFF_FFFE, 32'h0000_0001);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         DIV_LAT,  "div",      32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,  "div ovf",  32'h0000_0000, 32'h8000_0000);

    hi_we = 1'b1; wd = 32'h11; step();
    hi_we = 1'b0; lo_we = 1'b1; wd = 32'h22; step();
    lo_we = 1'b0;
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    run_op(MD_DIVU, 32'h1234_5678, 32'd0, DIV_LAT, "divu by zero", 32'h11, 32'h22);

    // start and mthi during busy, plus mtlo on the completion edge, must all be dropped
    op = MD_MULT; a = 32'd7; b = 32'd9; start = 1'b1; step();
    start = 1'b0; step();
    op = MD_MULT; a = 32'd2; b = 32'd2; start = 1'b1; hi_we = 1'b1; wd = 32'hDEAD; step();
    start = 1'b0; hi_we = 1'b0; step();
    step();
    lo_we = 1'b1; wd = 32'hBEEF; step();
    lo_we = 1'b0;
    check("ignore busy", {31'd0, busy}, 32'd0);
    check("ignore HI", hi, 32'd0);
    check("ignore LO", lo, 32'd63);

    hi_we = 1'b1; wd = 32'hABCD; step();
    hi_we = 1'b0;
    op = MD_DIV; a = 32'd100; b = 32'd7; start = 1'b1; step();
    start = 1'b0;
    repeat (4) step();
    #3 reset = 1'b0;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset HI", hi, 32'd0);
    check("async reset LO", lo, 32'd0);
    step();
    reset = 1'b1;
    repeat (15) step();
    check("post reset busy", {31'd0, busy}, 32'd0);
    check("post reset HI", hi, 32'd0);
    check("post reset LO", lo, 32'd0);

    for (int i = 0; i < 1200; i++) begin
      start = ($urandom % 4 == 0);
      op    = 2'($urandom);
      a     = pick_operand(1'b1);
      b     = ($urandom % 10 == 0) ? 32'd0 : pick_operand(1'b0);
      hi_we = ($urandom % 6 == 0);
      lo_we = ($urandom % 6 == 0);
      wd    = $urandom;
      step();
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("final idle", {31'd0, busy}, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
